// File: rtl/arm_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO subsystem: I/O page offsets,
// CTRL register bit positions and the packed CTRL register type.
// Optional feature macro: ARM_MMIO_PRESCALE_EN (adds the PRESC register).
package arm_mmio_pkg;

  localparam logic [7:0] OFF_LEDS  = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_COUNT = 8'h08;
  localparam logic [7:0] OFF_CTRL  = 8'h0C;
  localparam logic [7:0] OFF_LOAD  = 8'h10;
  localparam logic [7:0] OFF_PRESC = 8'h14;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_PEND_BIT = 2;
  localparam int CTRL_IE_BIT   = 3;

  // Field order matches the bit indices above (ie is bit 3, en is bit 0).
  typedef struct packed {
    logic ie;
    logic pend;
    logic auto_rl;
    logic en;
  } ctrl_t;

  // CTRL as seen on the read bus; unused upper bits read as zero.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {28'h0000000, c};
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer with auto-reload, W1C pending flag and interrupt.
// With ARM_MMIO_PRESCALE_EN defined, an 8-bit prescaler gates the ticks;
// otherwise the timer ticks every cycle.
import arm_mmio_pkg::*;

module mmio_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_count_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_load_i,
`ifdef ARM_MMIO_PRESCALE_EN
  input  logic        wr_presc_i,
  output logic [7:0]  presc_o,
`endif
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] load_o,
  output logic [31:0] ctrl_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] load_q, load_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        tick_s;
  logic        event_s;

`ifdef ARM_MMIO_PRESCALE_EN
  logic [7:0] presc_q, presc_d;
  logic [7:0] psc_q, psc_d;

  assign tick_s  = (psc_q == presc_q);
  assign presc_o = presc_q;

  // Prescaler: PRESC write, counter wraps on a tick, cleared while disabled.
  always_comb begin
    presc_d = presc_q;
    psc_d   = psc_q;
    if (wr_presc_i) begin
      presc_d = wdata_i[7:0];
    end else begin
      presc_d = presc_q;
    end
    if (!ctrl_q.en || wr_presc_i) begin
      psc_d = 8'h00;
    end else if (tick_s) begin
      psc_d = 8'h00;
    end else begin
      psc_d = psc_q + 8'h01;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= 8'h00;
      psc_q   <= 8'h00;
    end else begin
      presc_q <= presc_d;
      psc_q   <= psc_d;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Terminal-count event: the tick that takes COUNT from 1.
  assign event_s = ctrl_q.en & tick_s & (count_q == 32'd1);

  // Next-state: software COUNT write beats decrement/reload; a hardware
  // PEND set beats a same-cycle W1C clear.
  always_comb begin
    count_d = count_q;
    load_d  = load_q;
    ctrl_d  = ctrl_q;

    if (wr_load_i) begin
      load_d = wdata_i;
    end else begin
      load_d = load_q;
    end

    if (wr_count_i) begin
      count_d = wdata_i;
    end else if (ctrl_q.en && tick_s && (count_q > 32'd1)) begin
      count_d = count_q - 32'd1;
    end else if (event_s) begin
      count_d = ctrl_q.auto_rl ? load_q : 32'd0;
    end else begin
      count_d = count_q;
    end

    if (wr_ctrl_i) begin
      ctrl_d.en      = wdata_i[CTRL_EN_BIT];
      ctrl_d.auto_rl = wdata_i[CTRL_AUTO_BIT];
      ctrl_d.ie      = wdata_i[CTRL_IE_BIT];
    end else begin
      ctrl_d.en      = ctrl_q.en;
      ctrl_d.auto_rl = ctrl_q.auto_rl;
      ctrl_d.ie      = ctrl_q.ie;
    end

    if (event_s) begin
      ctrl_d.pend = 1'b1;
    end else if (wr_ctrl_i && wdata_i[CTRL_PEND_BIT]) begin
      ctrl_d.pend = 1'b0;
    end else begin
      ctrl_d.pend = ctrl_q.pend;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 32'd0;
      load_q  <= 32'd0;
      ctrl_q  <= '0;
    end else begin
      count_q <= count_d;
      load_q  <= load_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign count_o = count_q;
  assign load_o  = load_q;
  assign ctrl_o  = ctrl_to_word(ctrl_q);
  assign irq_o   = ctrl_q.pend & ctrl_q.ie;

endmodule

// File: rtl/arm_dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM (Adr[31]=0) and an
// I/O page (Adr[31]=1) with LEDs, synchronized switches and a timer.
// Optional feature macro: ARM_MMIO_PRESCALE_EN (PRESC register at 0x14).
import arm_mmio_pkg::*;

module arm_dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       Adr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [GPIO_W-1:0] Switches,
  output logic [GPIO_W-1:0] Leds,
  output logic              Irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]       mem_q [RAM_WORDS];
  logic [AW-1:0]     ram_idx_s;
  logic [7:0]        io_off_s;
  logic              wr_ram_s, wr_io_s;
  logic [GPIO_W-1:0] leds_q;
  logic [GPIO_W-1:0] sw_meta_q, sw_sync_q;
  logic [31:0]       io_rdata_s;
  logic [31:0]       count_s, load_s, ctrl_s;
  logic              unused_adr_s;

  // Byte lane and the middle of the I/O page address are don't-care.
  assign unused_adr_s = &{1'b0, Adr[30:8], Adr[1:0]};

  assign ram_idx_s = Adr[AW+1:2];
  assign io_off_s  = {Adr[7:2], 2'b00};
  assign wr_ram_s  = MemWrite & ~Adr[31];
  assign wr_io_s   = MemWrite & Adr[31];

  // Data RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ram_s) begin
      mem_q[ram_idx_s] <= WriteData;
    end
  end

  // LED register and two-flop switch synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      if (wr_io_s && (io_off_s == OFF_LEDS)) begin
        leds_q <= WriteData[GPIO_W-1:0];
      end
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef ARM_MMIO_PRESCALE_EN
  logic [7:0] presc_s;
`endif

  mmio_timer u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .wr_count_i (wr_io_s && (io_off_s == OFF_COUNT)),
    .wr_ctrl_i  (wr_io_s && (io_off_s == OFF_CTRL)),
    .wr_load_i  (wr_io_s && (io_off_s == OFF_LOAD)),
`ifdef ARM_MMIO_PRESCALE_EN
    .wr_presc_i (wr_io_s && (io_off_s == OFF_PRESC)),
    .presc_o    (presc_s),
`endif
    .wdata_i    (WriteData),
    .count_o    (count_s),
    .load_o     (load_s),
    .ctrl_o     (ctrl_s),
    .irq_o      (Irq)
  );

  // I/O read mux; unmapped offsets read zero.
  always_comb begin
    io_rdata_s = 32'h0000_0000;
    case (io_off_s)
      OFF_LEDS:  io_rdata_s = {{(32-GPIO_W){1'b0}}, leds_q};
      OFF_SW:    io_rdata_s = {{(32-GPIO_W){1'b0}}, sw_sync_q};
      OFF_COUNT: io_rdata_s = count_s;
      OFF_CTRL:  io_rdata_s = ctrl_s;
      OFF_LOAD:  io_rdata_s = load_s;
`ifdef ARM_MMIO_PRESCALE_EN
      OFF_PRESC: io_rdata_s = {24'h000000, presc_s};
`endif
      default:   io_rdata_s = 32'h0000_0000;
    endcase
  end

  assign ReadData = Adr[31] ? io_rdata_s : mem_q[ram_idx_s];
  assign Leds     = leds_q;

endmodule

// File: tb/tb_arm_dmem_mmio.sv
// Self-checking bench for arm_dmem_mmio: a table of RAM/GPIO/register
// accesses followed by hand-written timer, synchronizer and reset sequences.
module tb_arm_dmem_mmio;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [15:0] Switches;
  logic [15:0] Leds;
  logic        Irq;

  int n_checks;
  int n_fail;

  localparam logic [31:0] A_LEDS  = 32'h8000_0000;
  localparam logic [31:0] A_SW    = 32'h8000_0004;
  localparam logic [31:0] A_COUNT = 32'h8000_0008;
  localparam logic [31:0] A_CTRL  = 32'h8000_000C;
  localparam logic [31:0] A_LOAD  = 32'h8000_0010;
  localparam logic [31:0] A_PRESC = 32'h8000_0014;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs[16];

  arm_dmem_mmio #(.RAM_WORDS(64), .GPIO_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Adr       (Adr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Switches  (Switches),
    .Leds      (Leds),
    .Irq       (Irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Adr       = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    WriteData = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    MemWrite = 1'b0;
    Adr      = a;
    #1;
    check32(nm, ReadData, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    Adr       = 32'h0;
    WriteData = 32'h0;
    Switches  = 16'h0000;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, "ram_wr"};
    vecs[1]  = '{1'b0, 32'h0000_0104, 32'hDEAD_BEEF, "ram_alias_104"};
    vecs[2]  = '{1'b0, 32'h0000_0007, 32'hDEAD_BEEF, "ram_bytelane_007"};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, "ram_wr2"};
    vecs[4]  = '{1'b0, 32'h7FFF_FF08, 32'h1122_3344, "ram_alias_high"};
    vecs[5]  = '{1'b1, A_LEDS,        32'h1234_A5A5, "leds_wr"};
    vecs[6]  = '{1'b0, A_LEDS,        32'h0000_A5A5, "leds_rd"};
    vecs[7]  = '{1'b0, 32'h8000_0003, 32'h0000_A5A5, "leds_rd_bytelane"};
    vecs[8]  = '{1'b0, 32'h8000_0100, 32'h0000_A5A5, "leds_rd_alias"};
    vecs[9]  = '{1'b1, A_LOAD,        32'hCAFE_F00D, "load_wr"};
    vecs[10] = '{1'b0, A_LOAD,        32'hCAFE_F00D, "load_rd"};
    vecs[11] = '{1'b0, 32'h8000_0018, 32'h0000_0000, "unmapped_18"};
    vecs[12] = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, "unmapped_wr"};
    vecs[13] = '{1'b0, 32'h8000_0020, 32'h0000_0000, "unmapped_20"};
    vecs[14] = '{1'b0, A_PRESC,       32'h0000_0000, "presc_or_unmapped"};
    vecs[15] = '{1'b0, A_SW,          32'h0000_0000, "sw_idle"};

    // Reset state while reset is held.
    #2;
    check32("rst_leds", {16'h0, Leds}, 32'h0);
    check32("rst_irq", {31'h0, Irq}, 32'h0);
    rd(A_COUNT, 32'h0, "rst_count");
    rd(A_CTRL, 32'h0, "rst_ctrl");
    #6;
    reset = 1'b0;

    // Table-driven RAM / GPIO / register accesses.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].adr, vecs[i].data);
      end else begin
        rd(vecs[i].adr, vecs[i].data, vecs[i].name);
        step();
      end
    end
    check32("leds_pins", {16'h0, Leds}, 32'h0000_A5A5);

    // Strobe low: no write side effects.
    MemWrite  = 1'b0;
    Adr       = A_LEDS;
    WriteData = 32'h0000_FFFF;
    step();
    check32("no_strobe_leds", {16'h0, Leds}, 32'h0000_A5A5);

    // Read of the word being written returns old contents.
    MemWrite  = 1'b1;
    Adr       = 32'h0000_0004;
    WriteData = 32'h0000_0055;
    #1;
    check32("ram_rdw_old", ReadData, 32'hDEAD_BEEF);
    step();
    MemWrite = 1'b0;
    rd(32'h0000_0004, 32'h0000_0055, "ram_rdw_new");

    // Switch synchronizer: two edges of latency.
    Switches = 16'h00FF;
    step();
    rd(A_SW, 32'h0, "sw_after_1_edge");
    step();
    rd(A_SW, 32'h0000_00FF, "sw_after_2_edges");

    // One-shot countdown.
    wr(A_LOAD, 32'd3);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 3; k++) begin
      step();
      rd(A_COUNT, 32'd2 - k, "oneshot_count");
      check32("oneshot_irq", {31'h0, Irq}, (k == 2) ? 32'h1 : 32'h0);
    end
    rd(A_CTRL, 32'hD, "oneshot_ctrl_pend");
    step();
    rd(A_COUNT, 32'd0, "oneshot_hold0");
    wr(A_CTRL, 32'h4);
    rd(A_CTRL, 32'h0, "oneshot_clear");
    check32("oneshot_irq_clear", {31'h0, Irq}, 32'h0);

    // Auto-reload and W1C race.
    wr(A_LOAD, 32'd2);
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'hB);
    step();
    rd(A_COUNT, 32'd1, "auto_count1");
    wr(A_CTRL, 32'hF);
    rd(A_CTRL, 32'hF, "race_pend_wins");
    check32("race_irq", {31'h0, Irq}, 32'h1);
    rd(A_COUNT, 32'd2, "auto_reload");
    wr(A_CTRL, 32'hF);
    rd(A_CTRL, 32'hB, "w1c_clear");
    check32("w1c_irq", {31'h0, Irq}, 32'h0);
    rd(A_COUNT, 32'd1, "auto_count1b");
    step();
    rd(A_COUNT, 32'd2, "auto_reload2");
    check32("auto_irq2", {31'h0, Irq}, 32'h1);
    wr(A_COUNT, 32'd50);
    rd(A_COUNT, 32'd50, "sw_count_override");
    wr(A_CTRL, 32'h4);
    rd(A_CTRL, 32'h0, "stop_ctrl");
    rd(A_COUNT, 32'd49, "stop_count");

    // Reset asserted asynchronously mid-count.
    wr(A_LOAD, 32'd100);
    wr(A_COUNT, 32'd1);
    wr(A_CTRL, 32'hB);
    step();
    rd(A_COUNT, 32'd100, "pre_rst_reload");
    check32("pre_rst_irq", {31'h0, Irq}, 32'h1);
    step();
    rd(A_COUNT, 32'd99, "pre_rst_count");
    #2;
    reset = 1'b1;
    #1;
    check32("async_rst_irq", {31'h0, Irq}, 32'h0);
    check32("async_rst_leds", {16'h0, Leds}, 32'h0);
    rd(A_COUNT, 32'h0, "async_rst_count");
    rd(A_CTRL, 32'h0, "async_rst_ctrl");
    rd(A_SW, 32'h0, "async_rst_sw");
    reset = 1'b0;
    step();
    step();
    step();
    rd(A_COUNT, 32'h0, "post_rst_count");
    rd(A_LOAD, 32'h0, "post_rst_load");
    rd(A_SW, 32'h0000_00FF, "post_rst_sw");

`ifdef ARM_MMIO_PRESCALE_EN
    // Prescaled countdown: a tick every PRESC+1 cycles.
    wr(A_PRESC, 32'd3);
    rd(A_PRESC, 32'd3, "presc_rd");
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 3) rd(A_COUNT, 32'd2, "presc_count_c3");
      if (c == 4) rd(A_COUNT, 32'd1, "presc_count_c4");
      if (c == 7) rd(A_COUNT, 32'd1, "presc_count_c7");
      if (c == 7) rd(A_CTRL, 32'h1, "presc_nopend_c7");
      if (c == 8) rd(A_COUNT, 32'd0, "presc_count_c8");
      if (c == 8) rd(A_CTRL, 32'h5, "presc_pend_c8");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
